// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: synchronises and debounces two push buttons and turns accepted press edges into one-cycle SR commands.
// Optional macro SR_CMD_GEN_RESET_PRIORITY_EN: simultaneous presses issue r instead of being dropped.
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic set_db,
    output logic reset_db,
    output logic conflict
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;

    // bit 0 is the set channel, bit 1 the reset channel
    logic [1:0] meta_q, sync_q, db_q, db_d, press;
    state_t st_q [2];
    state_t st_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic s_q, r_q, conflict_q, s_d, r_d, conflict_d;

    // debounce each channel: the idle states hold cnt at 0, so the accept test cnt==DEBOUNCE_CYCLES-1 also covers DEBOUNCE_CYCLES=1
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            press[i] = 1'b0;
            case (st_q[i])
                IDLE_LOW, CHECK_HIGH: begin
                    if (!sync_q[i]) begin
                        st_d[i] = IDLE_LOW;
                    end else if (cnt_q[i] == LAST) begin
                        st_d[i]  = IDLE_HIGH;
                        db_d[i]  = 1'b1;
                        press[i] = 1'b1;
                    end else begin
                        st_d[i]  = CHECK_HIGH;
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                IDLE_HIGH, CHECK_LOW: begin
                    if (sync_q[i]) begin
                        st_d[i] = IDLE_HIGH;
                    end else if (cnt_q[i] == LAST) begin
                        st_d[i] = IDLE_LOW;
                        db_d[i] = 1'b0;
                    end else begin
                        st_d[i]  = CHECK_LOW;
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: st_d[i] = IDLE_LOW;
            endcase
        end
        s_d        = press[0] & ~press[1];
`ifdef SR_CMD_GEN_RESET_PRIORITY_EN
        r_d        = press[1];
`else
        r_d        = press[1] & ~press[0];
`endif
        conflict_d = press[0] & press[1];
    end

    // synchronisers, debounce state and registered commands; reset discards any count or pending pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            db_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= IDLE_LOW;
                cnt_q[i] <= '0;
            end
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            meta_q     <= {reset_in, set_in};
            sync_q     <= meta_q;
            db_q       <= db_d;
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign set_db   = db_q[0];
    assign reset_db = db_q[1];
endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: scoreboard bench for sr_cmd_gen, run-length reference model plus directed latency/count checks.
module tb_sr_cmd_gen;
    localparam int D = 4;
`ifdef SR_CMD_GEN_RESET_PRIORITY_EN
    localparam bit RP = 1'b1;
`else
    localparam bit RP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_in = 1'b0;
    logic reset_in = 1'b0;
    logic s, r, set_db, reset_db, conflict;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int s_cnt = 0, r_cnt = 0, c_cnt = 0;
    int s_last = -1, r_last = -1;
    bit inv_on = 1'b0;

    logic [1:0] m_meta = '0, m_sync = '0, m_db = '0;
    int m_run [2] = '{0, 0};
    logic [4:0] exp_q [$];

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
        .s(s), .r(r), .set_db(set_db), .reset_db(reset_db), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, n);
        end
    endtask

    // drive one cycle, push the model's expectation, then pop and compare after the edge
    task automatic cyc(input logic si, input logic ri, input logic rs);
        logic [1:0] acc;
        logic [4:0] e;
        acc = 2'b00;
        set_in = si;
        reset_in = ri;
        rst = rs;
        if (rs) begin
            m_meta = '0;
            m_sync = '0;
            m_db = '0;
            m_run = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_sync[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i] = ~m_db[i];
                        m_run[i] = 0;
                        acc[i] = m_db[i];
                    end
                end else m_run[i] = 0;
            end
            m_sync = m_meta;
            m_meta = {ri, si};
        end
        exp_q.push_back({acc[0] & ~acc[1], RP ? acc[1] : (acc[1] & ~acc[0]), acc[0] & acc[1], m_db[0], m_db[1]});
        @(posedge clk);
        #1;
        n++;
        e = exp_q.pop_front();
        chk("s", s, e[4]);
        chk("r", r, e[3]);
        chk("conflict", conflict, e[2]);
        chk("set_db", set_db, e[1]);
        chk("reset_db", reset_db, e[0]);
        if (s) begin s_cnt++; s_last = n; end
        if (r) begin r_cnt++; r_last = n; end
        if (conflict) c_cnt++;
    endtask

    always @(negedge clk) if (inv_on) chk("s_and_r", s & r, 0);

    initial begin
        int st, s0, r0, c0;
        logic si, ri;
        inv_on = 1'b1;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("rst_s", s, 0);
        chk("rst_set_db", set_db, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
        chk("idle_pulses", s_cnt + r_cnt + c_cnt, 0);

        st = n + 1; s0 = s_cnt;
        for (int i = 0; i < 14; i++) cyc(1, 0, 0);
        chk("set_lat", s_last - st, D + 1);
        chk("set_once", s_cnt - s0, 1);
        chk("set_db_held", set_db, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        chk("set_db_rel", set_db, 0);

        r0 = r_cnt;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
        chk("glitch_r", r_cnt - r0, 0);
        st = n + 1;
        for (int i = 0; i < 6; i++) cyc(0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);
        chk("press6_r", r_cnt - r0, 1);
        chk("press6_lat", r_last - st, D + 1);

        s0 = s_cnt; r0 = r_cnt; c0 = c_cnt;
        for (int i = 0; i < 10; i++) cyc(1, 1, 0);
        chk("simul_conflict", c_cnt - c0, 1);
        chk("simul_s", s_cnt - s0, 0);
        chk("simul_r", r_cnt - r0, RP ? 1 : 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);

        s0 = s_cnt;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("midrst_none", s_cnt - s0, 0);
        st = n + 1;
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);
        chk("midrst_once", s_cnt - s0, 1);
        chk("midrst_lat", s_last - st, D + 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);

        s0 = s_cnt; r0 = r_cnt;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0);
        chk("order_cnt", (s_cnt - s0) + (r_cnt - r0), 2);
        chk("order_gap", r_last - s_last, 2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0);

        si = 1'b0; ri = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(5) == 0) si = ~si;
            if ($urandom_range(5) == 0) ri = ~ri;
            cyc(si, ri, $urandom_range(99) == 0);
        end

        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
